// File: rtl/koa_seq_divider_if.sv
// Handshake and operand/result bundle for koa_seq_divider.
// The master drives the request and operands; the slave (divider) returns status and results.
interface koa_seq_divider_if #(
  parameter int SW = 24
);
  logic          start_i;
  logic [SW-1:0] Data_A_i;
  logic [SW-1:0] Data_B_i;
  logic          busy_o;
  logic          done_o;
  logic [SW-1:0] quotient_o;
  logic [SW-1:0] remainder_o;
  logic          div_zero_o;

  modport master (
    output start_i, Data_A_i, Data_B_i,
    input  busy_o, done_o, quotient_o, remainder_o, div_zero_o
  );

  modport slave (
    input  start_i, Data_A_i, Data_B_i,
    output busy_o, done_o, quotient_o, remainder_o, div_zero_o
  );
endinterface

// File: rtl/koa_seq_divider.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per clock.
// Define APPROX_DIV_EN to skip the TRUNC low quotient iterations for shorter latency.
module koa_seq_divider #(
  parameter int SW    = 24,
  parameter int TRUNC = 4
) (
  input logic             clk,
  input logic             rst,
  koa_seq_divider_if.slave bus
);

  if (SW < 4 || SW > 64) begin : g_bad_sw
    $error("koa_seq_divider: SW must be in 4..64");
  end
  if (TRUNC < 0 || TRUNC >= SW) begin : g_bad_trunc
    $error("koa_seq_divider: TRUNC must be in 0..SW-1");
  end

`ifdef APPROX_DIV_EN
  localparam int N  = SW - TRUNC;
`else
  localparam int N  = SW;
`endif
  localparam int CW = $clog2(SW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] a_reg, b_reg, q_reg, r_reg;
  logic [CW-1:0] cnt;
  logic          dz_reg;
  logic [SW-1:0] quotient, remainder;
  logic          div_zero;

  // The partial remainder is always < B, so SW bits hold it; the extra
  // trial bit T[SW] plus the borrow of an SW+1-bit subtract decide T >= B.
  logic [SW:0]   t_val;
  logic [SW-1:0] diff, r_next, q_next, a_next;
  logic          brw, ge;

  always_comb begin
    t_val         = {r_reg, a_reg[SW-1]};
    {brw, diff}   = {1'b0, t_val[SW-1:0]} - {1'b0, b_reg};
    ge            = t_val[SW] | ~brw;
    r_next        = ge ? diff : t_val[SW-1:0];
    q_next        = {q_reg[SW-2:0], ge};
    a_next        = {a_reg[SW-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.busy_o  = (state != IDLE);
    bus.done_o  = (state == DONE);
    case (state)
      IDLE:    if (bus.start_i) state_nxt = CALC;
      CALC:    if (cnt == '0)   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A zero divisor spends a single CALC cycle (count 0) so its completion
  // lands one edge after acceptance, with the iteration datapath frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      cnt       <= '0;
      dz_reg    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            a_reg  <= bus.Data_A_i;
            b_reg  <= bus.Data_B_i;
            q_reg  <= '0;
            r_reg  <= '0;
            dz_reg <= (bus.Data_B_i == '0);
            cnt    <= (bus.Data_B_i == '0) ? '0 : CW'(N - 1);
          end
        end
        CALC: begin
          if (!dz_reg) begin
            a_reg <= a_next;
            r_reg <= r_next;
            q_reg <= q_next;
          end
          if (cnt == '0) begin
            if (dz_reg) begin
              quotient  <= '1;
              remainder <= a_reg;
              div_zero  <= 1'b1;
            end else begin
`ifdef APPROX_DIV_EN
              // After N shifts the untouched low dividend bits sit at the top of a_next.
              quotient  <= q_next << TRUNC;
              remainder <= (r_next << TRUNC) | (a_next >> N);
`else
              quotient  <= q_next;
              remainder <= r_next;
`endif
              div_zero  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient_o  = quotient;
  assign bus.remainder_o = remainder;
  assign bus.div_zero_o  = div_zero;

endmodule
